// File: rtl/bsram_list_pkg.sv
// Shared types and constants for the BSRAM linked-list engine.
package bsram_list_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_WR_NODE = 3'd1;
    localparam state_t ST_RD_NODE = 3'd2;
    localparam state_t ST_EMIT    = 3'd3;
    localparam state_t ST_FIN     = 3'd4;

    localparam logic OP_BUILD = 1'b0;
    localparam logic OP_WALK  = 1'b1;

    localparam int NULL_ADDR = 0;

    function automatic int node_words(input int payload_words, input int ptr_words);
        return payload_words + ptr_words;
    endfunction

endpackage

// File: rtl/bsram_rd_align.sv
// Delay line that tags BSRAM read data with the node word index it was issued for.
module bsram_rd_align #(
    parameter int RD_LAT = 2,
    parameter int IDX_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_vld,
    input  logic [IDX_W-1:0] issue_idx,
    output logic             cap_vld,
    output logic [IDX_W-1:0] cap_idx
);

    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [IDX_W-1:0]  idx_q [RD_LAT];
    logic [IDX_W-1:0]  idx_d [RD_LAT];

    always_comb begin
        vld_d    = '0;
        vld_d[0] = issue_vld;
        idx_d[0] = issue_idx;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            idx_d[i] = idx_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) idx_q[i] <= '0;
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < RD_LAT; i++) idx_q[i] <= idx_d[i];
        end
    end

    assign cap_vld = vld_q[RD_LAT-1];
    assign cap_idx = idx_q[RD_LAT-1];

endmodule

// File: rtl/bsram_list_engine.sv
// Linked-list BUILD/WALK engine on one BSRAM port.
// Optional payload checksum output enabled by defining LIST_CHECKSUM_EN.
module bsram_list_engine
    import bsram_list_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int ADDR_W        = 11,
    parameter int PAYLOAD_WORDS = 2,
    parameter int PTR_WORDS     = 2,
    parameter int RD_LAT        = 2,
    parameter int MAX_HOPS      = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_op,
    input  logic [ADDR_W-1:0]               cmd_head,
    input  logic [ADDR_W-1:0]               cmd_stride,
    input  logic [ADDR_W-1:0]               cmd_count,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [PAYLOAD_WORDS*DATA_W-1:0] out_payload,
    output logic [ADDR_W-1:0]               out_addr,
    output logic                            done,
    output logic                            err,
    output logic [ADDR_W-1:0]               node_cnt,
`ifdef LIST_CHECKSUM_EN
    output logic [DATA_W-1:0]               csum,
`endif
    output logic                            mem_ce,
    output logic                            mem_we,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic [DATA_W-1:0]               mem_wdata,
    input  logic [DATA_W-1:0]               mem_rdata
);

    localparam int NB       = node_words(PAYLOAD_WORDS, PTR_WORDS);
    localparam int IDX_W    = $clog2(NB + 1);
    localparam int PAY_BITS = PAYLOAD_WORDS * DATA_W;
    localparam int PTR_BITS = PTR_WORDS * DATA_W;
    localparam logic [IDX_W-1:0]  PW_IDX   = IDX_W'(PAYLOAD_WORDS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NB - 1);
    localparam logic [IDX_W-1:0]  NB_IDX   = IDX_W'(NB);
    localparam logic [ADDR_W:0]   HOP_LIM  = (ADDR_W+1)'(MAX_HOPS);
    localparam logic [ADDR_W-1:0] NULL_A   = ADDR_W'(NULL_ADDR);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cur_q, cur_d;
    logic [ADDR_W-1:0]   stride_q, stride_d;
    logic [ADDR_W-1:0]   count_q, count_d;
    logic [IDX_W-1:0]    widx_q, widx_d;
    logic [ADDR_W-1:0]   node_cnt_q, node_cnt_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   pat_q, pat_d;
    logic [PAY_BITS-1:0] pay_q, pay_d;
    logic [PTR_BITS-1:0] ptr_q, ptr_d;

    logic [ADDR_W-1:0]   next_build, next_walk, cnt_inc;
    logic                last_node, issue, cap_vld;
    logic [IDX_W-1:0]    cap_idx;
    logic [PTR_BITS-1:0] ptr_ext;
    logic [DATA_W-1:0]   wr_word;

    assign next_build = cur_q + stride_q;
    assign cnt_inc    = node_cnt_q + ADDR_W'(1);
    assign last_node  = (cnt_inc == count_q);
    assign next_walk  = ptr_q[ADDR_W-1:0];
    assign issue      = (state_q == ST_RD_NODE) && (widx_q < NB_IDX);
    assign ptr_ext    = last_node ? '0 : PTR_BITS'(next_build);

    // Payload words carry the running pattern; pointer words go out MS word first.
    always_comb begin
        wr_word = pat_q;
        for (int j = 0; j < PTR_WORDS; j++) begin
            if (widx_q == IDX_W'(PAYLOAD_WORDS + j))
                wr_word = ptr_ext[(PTR_WORDS-1-j)*DATA_W +: DATA_W];
        end
    end

    bsram_rd_align #(
        .RD_LAT (RD_LAT),
        .IDX_W  (IDX_W)
    ) u_rd_align (
        .clk       (clk),
        .rst       (rst),
        .issue_vld (issue),
        .issue_idx (widx_q),
        .cap_vld   (cap_vld),
        .cap_idx   (cap_idx)
    );

`ifdef LIST_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d, pay_sum;

    always_comb begin
        pay_sum = '0;
        for (int p = 0; p < PAYLOAD_WORDS; p++) pay_sum = pay_sum + pay_q[p*DATA_W +: DATA_W];
    end
`endif

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        stride_d   = stride_q;
        count_d    = count_q;
        widx_d     = widx_q;
        node_cnt_d = node_cnt_q;
        err_d      = err_q;
        pat_d      = pat_q;
        pay_d      = pay_q;
        ptr_d      = ptr_q;
`ifdef LIST_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cur_d      = cmd_head;
                    stride_d   = cmd_stride;
                    count_d    = cmd_count;
                    widx_d     = '0;
                    node_cnt_d = '0;
                    err_d      = 1'b0;
                    pat_d      = '0;
`ifdef LIST_CHECKSUM_EN
                    csum_d     = '0;
`endif
                    case (cmd_op)
                        OP_BUILD: state_d = (cmd_count == '0 || cmd_head == NULL_A) ? ST_FIN : ST_WR_NODE;
                        OP_WALK:  state_d = (cmd_head == NULL_A) ? ST_FIN : ST_RD_NODE;
                    endcase
                end
            end
            ST_WR_NODE: begin
                if (widx_q < PW_IDX) begin
                    pat_d = pat_q + DATA_W'(1);
`ifdef LIST_CHECKSUM_EN
                    csum_d = csum_q + wr_word;
`endif
                end
                if (widx_q == LAST_IDX) begin
                    widx_d     = '0;
                    node_cnt_d = cnt_inc;
                    // A wrapped pointer was already written as NULL, so the chain stays terminated.
                    if (last_node || next_build == NULL_A) begin
                        err_d   = !last_node;
                        state_d = ST_FIN;
                    end else begin
                        cur_d = next_build;
                    end
                end else begin
                    widx_d = widx_q + IDX_W'(1);
                end
            end
            ST_RD_NODE: begin
                if (issue) widx_d = widx_q + IDX_W'(1);
                if (cap_vld) begin
                    if (cap_idx < PW_IDX) pay_d = (pay_q << DATA_W) | PAY_BITS'(mem_rdata);
                    else                  ptr_d = (ptr_q << DATA_W) | PTR_BITS'(mem_rdata);
                    if (cap_idx == LAST_IDX) state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    node_cnt_d = cnt_inc;
                    widx_d     = '0;
`ifdef LIST_CHECKSUM_EN
                    csum_d     = csum_q + pay_sum;
`endif
                    if (next_walk == NULL_A) begin
                        state_d = ST_FIN;
                    end else if ({1'b0, cnt_inc} >= HOP_LIM) begin
                        err_d   = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        cur_d   = next_walk;
                        state_d = ST_RD_NODE;
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            stride_q   <= '0;
            count_q    <= '0;
            widx_q     <= '0;
            node_cnt_q <= '0;
            err_q      <= 1'b0;
            pat_q      <= '0;
            pay_q      <= '0;
            ptr_q      <= '0;
`ifdef LIST_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            stride_q   <= stride_d;
            count_q    <= count_d;
            widx_q     <= widx_d;
            node_cnt_q <= node_cnt_d;
            err_q      <= err_d;
            pat_q      <= pat_d;
            pay_q      <= pay_d;
            ptr_q      <= ptr_d;
`ifdef LIST_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    // RAM strobes decode straight from state so reset drops them at once.
    assign mem_we      = (state_q == ST_WR_NODE);
    assign mem_ce      = mem_we || issue;
    assign mem_addr    = mem_ce ? cur_q + ADDR_W'(widx_q) : '0;
    assign mem_wdata   = mem_we ? wr_word : '0;

    assign cmd_ready   = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_EMIT);
    assign out_payload = pay_q;
    assign out_addr    = cur_q;
    assign done        = (state_q == ST_FIN);
    assign err         = err_q;
    assign node_cnt    = node_cnt_q;
`ifdef LIST_CHECKSUM_EN
    assign csum        = csum_q;
`endif

endmodule

// File: doc/bsram_list_engine.md
Name: bsram_list_engine

Overview:
- Parametrised linked-list engine driving one single-port view of a Gowin BSRAM (one DPB port).
- Two commands:
  - BUILD: writes a chain of fixed-size nodes into RAM.
  - WALK: traverses a chain from a head pointer and streams each node's payload out under a valid/ready handshake.
- Sits between control logic and the DPB primitive. Replaces ad-hoc per-test list sequencers.

Parameters:
- DATA_W, 8, RAM word width in bits.
- ADDR_W, 11, RAM address width. Address 0 is NULL and is never a valid node.
- PAYLOAD_WORDS, 2, payload words per node, stored first in the node.
- PTR_WORDS, 2, next-pointer words per node, stored big-endian after the payload. Must satisfy PTR_WORDS*DATA_W >= ADDR_W.
- RD_LAT, 2, RAM read latency in cycles: 1 = output register off, 2 = ocea/oceb on.
- MAX_HOPS, 1024, WALK loop guard.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  1  0 = BUILD, 1 = WALK.
- cmd_head  in  ADDR_W  first node address.
- cmd_stride  in  ADDR_W  BUILD node spacing.
- cmd_count  in  ADDR_W  BUILD node count.
- out_valid  out  1  payload available.
- out_ready  in  1  consumer accepts payload.
- out_payload  out  PAYLOAD_WORDS*DATA_W  node payload; word 0 in the MS bits.
- out_addr  out  ADDR_W  address of the emitted node.
- done  out  1  one-cycle pulse at command end.
- err  out  1  sticky until next accepted command: wrap-to-NULL (BUILD) or loop guard (WALK).
- node_cnt  out  ADDR_W  nodes written or emitted by the last command.
- mem_ce, mem_we  out  1  RAM clock-enable and write-enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data.

Behaviour:
- Reset (async): state IDLE; all outputs 0 except cmd_ready=1; mem_we deasserts immediately. A reset mid-operation abandons it; partial RAM contents are left as-is.
- Command acceptance: cmd_valid && cmd_ready registers cmd_*, clears err and node_cnt, leaves IDLE next cycle.
- NB = PAYLOAD_WORDS + PTR_WORDS. Node word k lives at cur + k, modulo 2^ADDR_W.
- States: IDLE, WR_NODE, RD_NODE, EMIT, FIN.
- BUILD:
  - cmd_count == 0 or cmd_head == 0: go straight to FIN, no writes.
  - WR_NODE: one write per cycle, NB cycles per node, mem_ce = mem_we = 1.
  - Payload word p of node i = (i*PAYLOAD_WORDS + p) mod 2^DATA_W.
  - Pointer = cur + cmd_stride for non-last nodes; 0 for the last node.
  - Non-last node whose computed next == 0: write a NULL pointer for that node, set err, go to FIN.
  - node_cnt increments after each node's last word is written.
- WALK:
  - head == 0: go to FIN, no reads.
  - RD_NODE: issue NB reads on consecutive cycles (mem_we = 0). Capture mem_rdata exactly RD_LAT cycles after each issue, into a payload shift register or the pointer register.
  - Pointer assembly: concatenate the PTR_WORDS words and truncate to ADDR_W LSBs.
  - After the last capture, go to EMIT: out_valid = 1 and out_payload/out_addr held stable until out_ready. There is no combinational ready-to-valid path.
  - On handshake: node_cnt++. If next == 0, go to FIN. Else if node_cnt+1 > MAX_HOPS, set err and go to FIN. Else cur = next and return to RD_NODE.
  - Minimum node period = NB + RD_LAT + 1 cycles.
- FIN: done = 1 for one cycle, then IDLE. cmd_ready returns the same cycle done pulses low.
- cmd_valid while busy is ignored. The engine never writes in WALK or reads in BUILD.

Optional Feature:
- Macro LIST_CHECKSUM_EN.
- Defined: adds output csum [DATA_W], the modulo-2^DATA_W sum of every payload word written (BUILD) or emitted (WALK). Cleared on command accept; valid while done pulses and held until the next accept.
- Undefined: no csum port, no adder logic.

Decomposition:
- Package bsram_list_pkg holds:
  - state enum;
  - op codes OP_BUILD=1'b0, OP_WALK=1'b1;
  - NULL_ADDR;
  - function computing NB.
- One natural sub-module, bsram_rd_align: an RD_LAT-deep valid/word-index delay line that tags returning read data with its node word index.

Test Plan:
- BUILD head=4, stride=64, count=10, then WALK head=4 with out_ready=1 -> payloads {00,01},{02,03},...,{12,13}; out_addr 4,68,...,580; node_cnt=10; done pulse; err=0.
- Same WALK with out_ready toggling 1-in-3 -> identical payload order; out_payload stable while out_valid && !out_ready; no reads issued during EMIT.
- Repeat both scenarios with RD_LAT=1 and RD_LAT=2 -> identical results; node period = NB+RD_LAT+1 cycles.
- BUILD head=2040, stride=8, count=3 (next wraps to 0) -> err=1, node_cnt=1, node 1 pointer words = 0x00 0x00; WALK head=0 -> done next cycle, no mem_ce.
- Build 3 nodes, then backdoor-write node 3's pointer = head, WALK with MAX_HOPS=16 -> 16 emits, err=1, done.
- Assert rst mid-BUILD (word 2 of node 5) -> mem_we=0 in the same cycle; outputs zero, cmd_ready=1 after release; a new command is accepted normally.
